// File: rtl/pa_pkg.sv
// Shared types and defaults for the packet assembler front end.
// Packet geometry is derived from DATASIZE, which must be a multiple of 8.
package pa_pkg;

   typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, PENDING} pa_state_e;

   localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
   localparam int unsigned DEFAULT_DATASIZE  = 192;
   localparam int unsigned PKT_BYTES         = DEFAULT_DATASIZE / 8;

   function automatic int unsigned pkt_bytes(input int unsigned datasize);
      return datasize / 8;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             i_clock,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clock) begin
      if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/packet_assembler.sv
// Sync-byte framed packet assembler: payload shift-in, XOR checksum, hold-until-free handoff.
// pkt_valid pulses once per good packet; full_packet only changes on a good-checksum commit.
module packet_assembler
   import pa_pkg::*;
#(
   parameter int unsigned DATASIZE  = DEFAULT_DATASIZE,
   parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic                rx_ready,
   input  logic                downstream_busy,
   output logic [DATASIZE-1:0] full_packet,
   output logic                pkt_valid,
   output logic [15:0]         pkt_count,
   output logic [15:0]         crc_err_count,
   output logic [15:0]         timeout_count
);

   localparam int unsigned NBYTES = pkt_bytes(DATASIZE);
   localparam int unsigned IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

   pa_state_e           r_state;
   logic [DATASIZE-1:0] r_shift;
   logic [DATASIZE-1:0] r_full_packet;
   logic                r_pkt_valid;
   logic [IW-1:0]       r_idx;
   logic [7:0]          r_xor;
   logic [TW-1:0]       r_timer;

   logic w_accept;
   logic w_in_pkt;
   logic w_timeout;
   logic w_crc_err;
   logic w_deliver;

   assign rx_ready  = (r_state != PENDING);
   assign w_accept  = rx_valid && rx_ready;
   assign w_in_pkt  = (r_state == PAYLOAD) || (r_state == CHECK);
   // An accepted byte on the expiry edge takes priority over the timeout.
   assign w_timeout = w_in_pkt && !w_accept && (r_timer == TO_LAST);
   assign w_crc_err = (r_state == CHECK) && w_accept && (rx_data != r_xor);
   assign w_deliver = (r_state == PENDING) && !downstream_busy;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= IDLE;
         r_shift       <= '0;
         r_full_packet <= '0;
         r_pkt_valid   <= 1'b0;
         r_idx         <= '0;
         r_xor         <= '0;
         r_timer       <= '0;
      end else begin
         r_pkt_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept && (rx_data == SYNC_BYTE)) begin
                  r_state <= PAYLOAD;
                  r_idx   <= '0;
                  r_xor   <= '0;
                  r_timer <= '0;
               end
            end
            PAYLOAD: begin
               if (w_accept) begin
                  r_shift <= {r_shift[DATASIZE-9:0], rx_data};
                  r_xor   <= r_xor ^ rx_data;
                  r_idx   <= r_idx + IW'(1);
                  r_timer <= '0;
                  if (r_idx == LAST_IDX) begin
                     r_state <= CHECK;
                  end
               end else if (w_timeout) begin
                  r_state <= IDLE;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            CHECK: begin
               if (w_accept) begin
                  r_timer <= '0;
                  if (rx_data == r_xor) begin
                     r_full_packet <= r_shift;
                     r_state       <= PENDING;
                  end else begin
                     r_state <= IDLE;
                  end
               end else if (w_timeout) begin
                  r_state <= IDLE;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            PENDING: begin
               if (w_deliver) begin
                  r_pkt_valid <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign full_packet = r_full_packet;
   assign pkt_valid   = r_pkt_valid;

   sat_counter #(.WIDTH(16)) u_pkt_cnt (
      .i_clock (clock),
      .i_clear (reset),
      .i_inc   (w_deliver),
      .o_count (pkt_count)
   );

   sat_counter #(.WIDTH(16)) u_crc_cnt (
      .i_clock (clock),
      .i_clear (reset),
      .i_inc   (w_crc_err),
      .o_count (crc_err_count)
   );

   sat_counter #(.WIDTH(16)) u_to_cnt (
      .i_clock (clock),
      .i_clear (reset),
      .i_inc   (w_timeout),
      .o_count (timeout_count)
   );

endmodule

// File: tb/tb_packet_assembler.sv
// Scoreboard bench for packet_assembler: directed packets push expected deliveries,
// a negedge monitor pops and compares packet contents and delivery cycle.
module tb_packet_assembler;

   localparam logic [191:0] P1  = 192'h0102030405060708090A0B0C0D0E0F101112131415161718;
   localparam logic [191:0] PA5 = 192'h0102030405A50708090A0B0C0D0E0F101112131415161718;
   localparam logic [191:0] PF0 = {8'hF0, 184'h0};

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [7:0]   rx_data = 8'h00;
   logic         rx_valid = 1'b0;
   logic         rx_ready;
   logic         downstream_busy = 1'b0;
   logic [191:0] full_packet;
   logic         pkt_valid;
   logic [15:0]  pkt_count;
   logic [15:0]  crc_err_count;
   logic [15:0]  timeout_count;

   typedef struct {
      logic [191:0] data;
      int unsigned  due;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned cyc = 0;
   int unsigned n_total = 0;
   int unsigned n_pass = 0;

   packet_assembler #(
      .DATASIZE  (192),
      .SYNC_BYTE (8'hA5),
      .TIMEOUT   (255)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .rx_ready        (rx_ready),
      .downstream_busy (downstream_busy),
      .full_packet     (full_packet),
      .pkt_valid       (pkt_valid),
      .pkt_count       (pkt_count),
      .crc_err_count   (crc_err_count),
      .timeout_count   (timeout_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
      n_total++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [191:0] p, input logic [7:0] cks);
      send_byte(8'hA5);
      for (int i = 0; i < 24; i++) send_byte(p[191-8*i -: 8]);
      send_byte(cks);
   endtask

   task automatic expect_pkt(input logic [191:0] p, input int unsigned due);
      exp_t e;
      e.data = p;
      e.due  = due;
      sb_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Monitor: every pkt_valid must match the oldest expected packet and its delivery cycle.
   always @(negedge clock) begin
      if (!reset && pkt_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_pkt_valid", 192'd1, 192'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("pkt_data", full_packet, e.data);
            check("pkt_latency", 192'(cyc), 192'(e.due));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      reset = 1'b1;
      idle(3);
      check("rst_rx_ready", rx_ready, 1'b1);
      check("rst_pkt_valid", pkt_valid, 1'b0);
      check("rst_full_packet", full_packet, 192'h0);
      check("rst_pkt_count", pkt_count, 16'd0);
      check("rst_crc_count", crc_err_count, 16'd0);
      check("rst_to_count", timeout_count, 16'd0);
      reset = 1'b0;
      idle(1);

      // Good packet, minimum latency
      send_pkt(P1, 8'h18);
      expect_pkt(P1, cyc + 1);
      idle(3);
      check("good_pkt_count", pkt_count, 16'd1);
      check("good_full_packet", full_packet, P1);

      // Bad checksum: nothing delivered, full_packet untouched
      send_pkt(192'h0, 8'h5A);
      idle(3);
      check("bad_crc_count", crc_err_count, 16'd1);
      check("bad_pkt_count", pkt_count, 16'd1);
      check("bad_full_kept", full_packet, P1);
      check("bad_rx_ready", rx_ready, 1'b1);

      // Backpressure: held in PENDING while busy
      downstream_busy = 1'b1;
      send_pkt(PF0, 8'hF0);
      for (int i = 0; i < 20; i++) begin
         idle(1);
         check("bp_rx_ready", rx_ready, 1'b0);
         check("bp_pkt_valid", pkt_valid, 1'b0);
         check("bp_full_stable", full_packet, PF0);
      end
      downstream_busy = 1'b0;
      expect_pkt(PF0, cyc + 1);
      idle(3);
      check("bp_pkt_count", pkt_count, 16'd2);

      // Timeout: 255 idle cycles after the 10th payload byte
      send_byte(8'hA5);
      for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
      idle(254);
      check("to_not_yet", timeout_count, 16'd0);
      idle(1);
      check("to_count", timeout_count, 16'd1);
      check("to_rx_ready", rx_ready, 1'b1);
      send_pkt(P1, 8'h18);
      expect_pkt(P1, cyc + 1);
      idle(3);
      check("to_after_pkt_count", pkt_count, 16'd3);

      // Noise before sync, sync value inside payload
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h3C);
      send_pkt(PA5, 8'hBB);
      expect_pkt(PA5, cyc + 1);
      idle(3);
      check("noise_pkt_count", pkt_count, 16'd4);
      check("noise_crc_count", crc_err_count, 16'd1);

      // Back-to-back: next sync accepted while pkt_valid is high
      send_pkt(P1, 8'h18);
      expect_pkt(P1, cyc + 1);
      idle(1);
      check("b2b_pkt_valid", pkt_valid, 1'b1);
      check("b2b_rx_ready", rx_ready, 1'b1);
      send_pkt(PF0, 8'hF0);
      expect_pkt(PF0, cyc + 1);
      idle(3);
      check("b2b_pkt_count", pkt_count, 16'd6);

      // Reset in the middle of a packet
      send_byte(8'hA5);
      for (int i = 0; i < 12; i++) send_byte(8'(i + 1));
      reset = 1'b1;
      idle(1);
      check("mid_rst_full", full_packet, 192'h0);
      check("mid_rst_pkt_count", pkt_count, 16'd0);
      check("mid_rst_crc_count", crc_err_count, 16'd0);
      check("mid_rst_to_count", timeout_count, 16'd0);
      check("mid_rst_rx_ready", rx_ready, 1'b1);
      check("mid_rst_pkt_valid", pkt_valid, 1'b0);
      reset = 1'b0;
      idle(1);
      send_pkt(P1, 8'h18);
      expect_pkt(P1, cyc + 1);
      idle(3);
      check("post_rst_pkt_count", pkt_count, 16'd1);

      // Every expected delivery must have been seen
      for (int i = 0; i < 10 && sb_q.size() != 0; i++) idle(1);
      check("sb_drained", 192'(sb_q.size()), 192'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
